// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EXE/MEM/WB over a req/ready
// memory port, halts on illegal instructions and keeps cycle/retire counters.
module mips_mc_ctrl #(
  parameter int PERF_W    = 32,
  parameter bit HAS_ADDIU = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              IorD,
  output logic              IRWr,
  output logic              PCWr,
  output logic [1:0]        nPC_sel,
  output logic              RegDst,
  output logic              RegWr,
  output logic [1:0]        ExtOp,
  output logic              ALUSrc,
  output logic [1:0]        ALUctr,
  output logic              MemWr,
  output logic              MemtoReg,
  output logic              retire,
  output logic              illegal,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt
);
  // state  | meaning
  // S_IF   | fetch over the memory port, load IR and PC+4 on ready
  // S_ID   | decode; J completes here, illegal ops halt
  // S_EXE  | ALU operation; BEQ resolves and completes here
  // S_MEM  | LW/SW data access, waits for ready
  // S_WB   | register-file write
  // S_HALT | illegal instruction seen, left only through reset
  typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT} state_t;

  state_t state, state_nxt;

  logic [5:0] opcode, funct;
  logic is_rtype, is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_addiu;
  logic legal;
  logic [1:0] d_ext, d_ctr;
  logic d_src, d_dst;
  logic unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[25:6];

  assign is_rtype = (opcode == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_ori   = (opcode == 6'b001101);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_lui   = (opcode == 6'b001111);
  assign is_j     = (opcode == 6'b000010);
  assign is_addiu = HAS_ADDIU && (opcode == 6'b001001);
  assign legal    = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_lui | is_j | is_addiu;

  // Datapath controls that stay constant from EXE through WB.
  always_comb begin
    d_ctr = 2'b00;
    d_ext = 2'b00;
    if (is_subu || is_beq) d_ctr = 2'b01;
    if (is_ori || is_lui)  d_ctr = 2'b10;
    if (is_lui)            d_ext = 2'b10;
    if (is_addiu || is_lw || is_sw) d_ext = 2'b01;
    d_src = is_ori | is_lui | is_addiu | is_lw | is_sw;
    d_dst = is_addu | is_subu;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:   if (mem_ready) state_nxt = S_ID;
      S_ID:   if (!legal)    state_nxt = S_HALT;
              else if (is_j) state_nxt = S_IF;
              else           state_nxt = S_EXE;
      S_EXE:  if (is_beq)              state_nxt = S_IF;
              else if (is_lw || is_sw) state_nxt = S_MEM;
              else                     state_nxt = S_WB;
      S_MEM:  if (mem_ready) state_nxt = is_sw ? S_IF : S_WB;
      S_WB:   state_nxt = S_IF;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Gated by rst so that a mid-instruction reset drops every strobe at once.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    nPC_sel  = 2'b00;
    RegDst   = 1'b0;
    RegWr    = 1'b0;
    ExtOp    = 2'b00;
    ALUSrc   = 1'b0;
    ALUctr   = 2'b00;
    MemWr    = 1'b0;
    MemtoReg = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    if (!rst) begin
      if (state inside {S_EXE, S_MEM, S_WB}) begin
        ExtOp  = d_ext;
        ALUSrc = d_src;
        ALUctr = d_ctr;
        RegDst = d_dst;
      end
      case (state)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWr = 1'b1;
            PCWr = 1'b1;
          end
        end
        S_ID: if (legal && is_j) begin
          PCWr    = 1'b1;
          nPC_sel = 2'b10;
          retire  = 1'b1;
        end
        S_EXE: if (is_beq) begin
          retire = 1'b1;
          if (zero) begin
            PCWr    = 1'b1;
            nPC_sel = 2'b01;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          MemWr   = is_sw;
          retire  = is_sw && mem_ready;
        end
        S_WB: begin
          RegWr    = 1'b1;
          MemtoReg = is_lw;
          retire   = 1'b1;
        end
        S_HALT: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (retire)          instr_cnt <= instr_cnt + PERF_W'(1);
    end
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS core. It is the successor to the single-cycle decoder: a state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives a shared memory port through a req/ready handshake and keeps performance counters. It sits between the instruction register and the multi-cycle datapath, and drives the same control-signal set plus the multi-cycle strobes.

## Interface
- PERF_W, 32, width of `cycle_cnt` and `instr_cnt`.
- HAS_ADDIU, 0, when 1, opcode 001001 (ADDIU) is legal; when 0, it is illegal.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- instruction  in  32  current IR contents. The datapath holds it stable between IRWr pulses.
- zero  in  1  ALU zero flag, valid in S_EXE.
- mem_ready  in  1  memory completion for the current `mem_req`.
- mem_req  out  1  memory access request.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- IRWr  out  1  IR load strobe.
- PCWr  out  1  PC load strobe.
- nPC_sel  out  2  next-PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- RegWr  out  1  register-file write strobe.
- ExtOp  out  2  immediate extension: 00 = zero-extend, 01 = sign-extend, 10 = imm<<16.
- ALUSrc  out  1  ALU B operand: 1 = immediate, 0 = rt.
- ALUctr  out  2  ALU operation: 00 = add, 01 = sub, 10 = or.
- MemWr  out  1  memory write qualifier, valid with `mem_req`.
- MemtoReg  out  1  write-back source: 1 = MDR, 0 = ALU result.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky flag for an illegal instruction.
- cycle_cnt  out  PERF_W  free-running cycle count.
- instr_cnt  out  PERF_W  count of retired instructions.

## Operation
- Decode:
  - Opcode 000000 with funct 100001 is ADDU; with funct 100011 it is SUBU. Any other funct is illegal.
  - 001101 ORI, 100011 LW, 101011 SW, 000100 BEQ, 001111 LUI, 000010 J.
  - 001001 ADDIU is legal only when HAS_ADDIU=1. Any other opcode is illegal.
- State encoding: S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT. Reset enters S_IF.
- Output generation:
  - Outputs are combinational from the state and `instruction`.
  - Any output not listed for the current state is 0.
  - ExtOp, ALUSrc, ALUctr and RegDst hold their instruction-derived values throughout S_EXE, S_MEM and S_WB.
- S_IF:
  - Drive mem_req=1, IorD=0, MemWr=0.
  - When mem_ready=1: pulse IRWr=1 and PCWr=1 with nPC_sel=00, then go to S_ID.
  - Otherwise stay in S_IF.
- S_ID:
  - Illegal instruction: set `illegal`, go to S_HALT.
  - J: PCWr=1, nPC_sel=10, retire=1, go to S_IF.
  - Anything else: go to S_EXE.
- S_EXE, by instruction class:
  - BEQ: ALUctr=01, ALUSrc=0. If zero=1, PCWr=1 with nPC_sel=01. Assert retire=1 and go to S_IF.
  - LW, SW: ALUctr=00, ALUSrc=1, ExtOp=01. Go to S_MEM.
  - ADDU: ALUctr=00, ALUSrc=0. Go to S_WB.
  - SUBU: ALUctr=01, ALUSrc=0. Go to S_WB.
  - ORI: ALUctr=10, ALUSrc=1, ExtOp=00. Go to S_WB.
  - LUI: ALUctr=10, ALUSrc=1, ExtOp=10. Go to S_WB.
  - ADDIU: ALUctr=00, ALUSrc=1, ExtOp=01. Go to S_WB.
- S_MEM:
  - Drive mem_req=1, IorD=1, and MemWr=1 for SW.
  - Wait for mem_ready=1. Then SW asserts retire=1 and goes to S_IF; LW goes to S_WB.
- S_WB:
  - Drive RegWr=1.
  - RegDst=1 for R-type, 0 otherwise. MemtoReg=1 for LW only.
  - Assert retire=1, go to S_IF.
- S_HALT:
  - All strobes 0, `illegal` held at 1.
  - Counters freeze. The block leaves S_HALT only through reset.
- Counters:
  - `cycle_cnt` increments every cycle outside S_HALT.
  - `instr_cnt` increments on `retire`.
  - Both wrap modulo 2^PERF_W; wrap is silent.

## Timing
- Reset values:
  - State S_IF; cycle_cnt=0, instr_cnt=0, illegal=0.
  - While rst=1, every output strobe is forced to 0: mem_req, IRWr, PCWr, RegWr, MemWr, retire.
- Reset mid-instruction aborts the instruction immediately:
  - No PCWr or RegWr is issued after rst rises.
  - An outstanding mem_req is dropped without waiting for mem_ready.
- Memory handshake:
  - mem_req stays high until the cycle in which mem_ready=1, inclusive.
  - Completion happens in that same cycle.
  - mem_ready while mem_req=0 is ignored.
- Cycle counts with zero-wait memory (mem_ready=1 on the first req cycle); each wait cycle adds one:
  - J: 2.
  - BEQ: 3.
  - SW: 4.
  - ADDU, SUBU, ORI, LUI, ADDIU: 4.
  - LW: 5.
- `retire` is high for exactly one cycle per instruction. It rises in the same cycle as the instruction's final PCWr or RegWr, and `instr_cnt` updates on the following edge.

## Test plan
- Reset, then ADDU with zero-wait memory:
  - Required: IRWr at cycle 0, RegWr with RegDst=1 at cycle 3, retire at cycle 3.
  - Required: instr_cnt=1, cycle_cnt=4.
- LW with mem_ready low for 2 cycles in S_IF and 3 cycles in S_MEM:
  - Required: RegWr with MemtoReg=1 at cycle 9.
  - Required: mem_req held continuously during each wait; IorD=1 only in S_MEM.
- BEQ with zero=1, then BEQ with zero=0:
  - Required: the first issues PCWr with nPC_sel=01 in S_EXE; the second issues no PCWr in S_EXE.
  - Required: 3 cycles each.
- Opcode 001001 with HAS_ADDIU=0:
  - Required: illegal=1 after S_ID, state S_HALT, counters frozen, no strobes.
  - Required: with HAS_ADDIU=1, the same instruction retires in 4 cycles with ExtOp=01.
- PERF_W=4, run 16 J instructions:
  - Required: instr_cnt wraps to 0 and cycle_cnt wraps to 0 after 32 cycles.
- Assert rst in S_MEM of a SW while mem_req=1:
  - Required: mem_req and MemWr drop asynchronously, no retire.
  - Required: after release, a fetch starts in S_IF with counters at 0.
